conv_column_feeder: RTL and testbench



---
 rtl/conv_pkg.sv | 33 +++
 rtl/conv_column_feeder_if.sv | 24 ++
 rtl/conv_gap_timer.sv | 22 ++
 rtl/conv_column_feeder.sv | 169 ++++++++++++++++
 tb/tb_conv_column_feeder.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared constants, FSM encoding and strobe-schedule helper for the conv column feeder.
// CONV_ZERO_PAD_EN adds one zero column on each side of the image ("same" output width).
package conv_pkg;

  localparam int BIT_LEN  = 8;
  localparam int ADDR_LEN = 10;
  localparam int M_LEN    = 3;
  localparam int CONV_LAT = 2;
  localparam int S_LEN    = ADDR_LEN + 2;

`ifdef CONV_ZERO_PAD_EN
  localparam int PAD = 1;
`else
  localparam int PAD = 0;
`endif

  // Narrowest image that still produces at least one result.
  localparam int MIN_WIDTH = (PAD != 0) ? 1 : M_LEN;

  typedef enum logic [2:0] {
    ST_IDLE, ST_K_RD, ST_K_CAP, ST_I_WAIT, ST_I_RD, ST_I_CAP, ST_FLUSH, ST_DONE
  } state_t;

  // Image strobe idx carries RAM data (1) or a zero pad/flush column (0).
  function automatic logic strobe_is_read(input logic [S_LEN-1:0] idx,
                                          input logic [ADDR_LEN-1:0] width);
    logic [S_LEN-1:0] w;
    w = {2'b00, width};
    if (PAD != 0) return (idx >= S_LEN'(1)) && (idx <= w);
    else return idx < w;
  endfunction

endpackage

// File: rtl/conv_column_feeder_if.sv
// Line-buffer RAM read port plus the convolver column-input bus.
// Handshake: one column is transferred in each cycle valid is high; there is no back-pressure.
interface conv_column_feeder_if;
  import conv_pkg::*;

  logic [ADDR_LEN-1:0] addr;
  logic                rd_en;
  logic [BIT_LEN-1:0]  rd0, rd1, rd2;
  logic [BIT_LEN-1:0]  dato0, dato1, dato2;
  logic                selecK_I;
  logic                valid;
  logic                res_valid;

  modport master (
    output addr, rd_en, dato0, dato1, dato2, selecK_I, valid, res_valid,
    input  rd0, rd1, rd2
  );

  modport slave (
    input  addr, rd_en, dato0, dato1, dato2, selecK_I, valid, res_valid,
    output rd0, rd1, rd2
  );

endinterface

// File: rtl/conv_gap_timer.sv
// Reloadable down-counter; o_fire marks the last wait cycle before the next image column.
module conv_gap_timer #(
    parameter int W = 3
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_count,
    output logic         o_fire
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)            r_cnt <= '0;
        else if (i_load)         r_cnt <= i_count;
        else if (r_cnt != '0)    r_cnt <= r_cnt - 1'b1;
    end

    assign o_fire = (r_cnt == W'(1));

endmodule

// File: rtl/conv_column_feeder.sv
// Streams 3 kernel columns then the image columns (plus a zero flush) into the 3x3 convolver.
// Build with CONV_ZERO_PAD_EN to pad the image with one zero column on each side.
module conv_column_feeder
    import conv_pkg::*;
#(
    parameter int GAP = 4
) (
    input  logic                CLK100MHZ,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [ADDR_LEN-1:0] i_width,
    input  logic [ADDR_LEN-1:0] i_kbase,
    input  logic [ADDR_LEN-1:0] i_ibase,
    output logic                o_busy,
    output logic                o_done,
    output state_t              o_dbg_state,
    conv_column_feeder_if.master bus
);

    localparam int TW = $clog2(GAP + 1);

    if (GAP < CONV_LAT + 1) begin : g_gap_check
        $error("GAP too small for the convolver pipeline");
    end

    state_t              r_state;
    logic [ADDR_LEN-1:0] r_width, r_kbase, r_ibase, r_addr;
    logic [1:0]          r_k;
    logic [S_LEN-1:0]    r_s, r_n;
    logic                r_rd_en, r_valid, r_sel, r_res_valid, r_busy, r_done;
    logic [BIT_LEN-1:0]  r_d0, r_d1, r_d2;

    logic [S_LEN-1:0]    w_nxt;
    logic                w_strobe_end, w_nxt_read, w_cur_read, w_last, w_tmr_load, w_fire;
    logic [TW-1:0]       w_tmr_count;
    logic [ADDR_LEN-1:0] w_col_addr;

    // r_s is the index of the image strobe in flight (or next to issue while waiting).
    always_comb begin
        w_strobe_end = (r_state == ST_I_CAP) || (r_state == ST_FLUSH) ||
                       ((r_state == ST_K_CAP) && (r_k == 2'd2));
        w_nxt        = (r_state == ST_K_CAP) ? r_s : r_s + 1'b1;
        w_nxt_read   = strobe_is_read(w_nxt, r_width);
        w_cur_read   = strobe_is_read(r_s, r_width);
        w_last       = (w_nxt == r_n);
        w_tmr_load   = w_strobe_end && !w_last;
        // A RAM column spends one cycle in I_RD, a zero column does not.
        w_tmr_count  = w_nxt_read ? TW'(GAP - 2) : TW'(GAP - 1);
        w_col_addr   = r_ibase + r_s[ADDR_LEN-1:0] - ADDR_LEN'(PAD);
    end

    conv_gap_timer #(.W(TW)) u_gap_timer (
        .i_clk   (CLK100MHZ),
        .i_rst_n (i_reset),
        .i_load  (w_tmr_load),
        .i_count (w_tmr_count),
        .o_fire  (w_fire)
    );

    always_ff @(posedge CLK100MHZ or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= ST_IDLE;
            r_width     <= '0;
            r_kbase     <= '0;
            r_ibase     <= '0;
            r_addr      <= '0;
            r_k         <= '0;
            r_s         <= '0;
            r_n         <= '0;
            r_rd_en     <= 1'b0;
            r_valid     <= 1'b0;
            r_sel       <= 1'b0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_d0        <= '0;
            r_d1        <= '0;
            r_d2        <= '0;
        end else begin
            r_rd_en     <= 1'b0;
            r_valid     <= 1'b0;
            r_res_valid <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                ST_IDLE: if (i_start) begin
                    r_width <= i_width;
                    r_kbase <= i_kbase;
                    r_ibase <= i_ibase;
                    r_n     <= S_LEN'(i_width) + S_LEN'(1 + 2 * PAD);
                    r_k     <= '0;
                    r_s     <= '0;
                    r_busy  <= 1'b1;
                    if (i_width < ADDR_LEN'(MIN_WIDTH)) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_rd_en <= 1'b1;
                        r_addr  <= i_kbase;
                        r_state <= ST_K_RD;
                    end
                end
                ST_K_RD: begin
                    r_d0    <= bus.rd0;
                    r_d1    <= bus.rd1;
                    r_d2    <= bus.rd2;
                    r_sel   <= 1'b0;
                    r_valid <= 1'b1;
                    r_state <= ST_K_CAP;
                end
                ST_K_CAP: begin
                    if (r_k == 2'd2) begin
                        r_state <= ST_I_WAIT;
                    end else begin
                        r_k     <= r_k + 2'd1;
                        r_rd_en <= 1'b1;
                        r_addr  <= r_kbase + ADDR_LEN'(r_k + 2'd1);
                        r_state <= ST_K_RD;
                    end
                end
                ST_I_WAIT: if (w_fire) begin
                    if (w_cur_read) begin
                        r_rd_en <= 1'b1;
                        r_addr  <= w_col_addr;
                        r_state <= ST_I_RD;
                    end else begin
                        r_d0    <= '0;
                        r_d1    <= '0;
                        r_d2    <= '0;
                        r_sel   <= 1'b1;
                        r_valid <= 1'b1;
                        r_state <= ST_FLUSH;
                    end
                end
                ST_I_RD: begin
                    r_d0    <= bus.rd0;
                    r_d1    <= bus.rd1;
                    r_d2    <= bus.rd2;
                    r_sel   <= 1'b1;
                    r_valid <= 1'b1;
                    r_state <= ST_I_CAP;
                end
                ST_I_CAP, ST_FLUSH: begin
                    // The convolver holds a full window once three columns precede this one.
                    r_res_valid <= (r_s >= S_LEN'(M_LEN));
                    r_s         <= r_s + 1'b1;
                    r_state     <= w_last ? ST_DONE : ST_I_WAIT;
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.addr      = r_addr;
    assign bus.rd_en     = r_rd_en;
    assign bus.dato0     = r_d0;
    assign bus.dato1     = r_d1;
    assign bus.dato2     = r_d2;
    assign bus.selecK_I  = r_sel;
    assign bus.valid     = r_valid;
    assign bus.res_valid = r_res_valid;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_conv_column_feeder.sv
// Scoreboard bench for conv_column_feeder: a column-list model feeds expected queues, a monitor checks.
// Honours CONV_ZERO_PAD_EN the same way as the design.
module tb_conv_column_feeder;
  import conv_pkg::*;

  localparam int GAP = 4;
  localparam int SW  = 1 + 3 * BIT_LEN;
  localparam int AMOD = 1 << ADDR_LEN;
  localparam int DMOD = 1 << BIT_LEN;
`ifdef CONV_ZERO_PAD_EN
  localparam int TB_PAD = 1;
`else
  localparam int TB_PAD = 0;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic                i_start;
  logic [ADDR_LEN-1:0] i_width, i_kbase, i_ibase;
  logic                o_busy, o_done;
  state_t              dbg_state;
  longint              cyc = 0;

  int n_cmp = 0;
  int n_fail = 0;
  int res_cnt = 0;
  int done_cnt = 0;

  logic [SW-1:0]       exp_q[$];
  logic [ADDR_LEN-1:0] addr_q[$];

  // ---------------- clock / reset / DUT ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_column_feeder_if bus();

  // RAM banks: bytes derived from the address; junk when no read is requested.
  assign bus.rd0 = bus.rd_en ? BIT_LEN'(bus.addr)        : 8'hA5;
  assign bus.rd1 = bus.rd_en ? BIT_LEN'(bus.addr) + 8'd1 : 8'hA5;
  assign bus.rd2 = bus.rd_en ? BIT_LEN'(bus.addr) + 8'd2 : 8'hA5;

  conv_column_feeder #(.GAP(GAP)) dut (
    .CLK100MHZ  (clk),
    .i_reset    (rst_n),
    .i_start    (i_start),
    .i_width    (i_width),
    .i_kbase    (i_kbase),
    .i_ibase    (i_ibase),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_dbg_state(dbg_state),
    .bus        (bus)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [SW-1:0] col_word(input bit sel, input int a);
    logic [BIT_LEN-1:0] b0, b1, b2;
    b0 = BIT_LEN'(a % DMOD);
    b1 = BIT_LEN'((a + 1) % DMOD);
    b2 = BIT_LEN'((a + 2) % DMOD);
    return {sel, b0, b1, b2};
  endfunction

  // ---------------- reference model ----------------
  // Builds the column list of a job; returns the number of result pulses expected.
  function automatic int model_job(input int width, input int kbase, input int ibase);
    int cols[$];
    if (width < ((TB_PAD != 0) ? 1 : 3)) return 0;
    for (int k = 0; k < 3; k++) begin
      addr_q.push_back(ADDR_LEN'((kbase + k) % AMOD));
      exp_q.push_back(col_word(1'b0, (kbase + k) % AMOD));
    end
    if (TB_PAD != 0) cols.push_back(-1);
    for (int c = 0; c < width; c++) cols.push_back((ibase + c) % AMOD);
    if (TB_PAD != 0) cols.push_back(-1);
    cols.push_back(-1);
    foreach (cols[i]) begin
      if (cols[i] < 0) begin
        exp_q.push_back({1'b1, {(3 * BIT_LEN){1'b0}}});
      end else begin
        addr_q.push_back(ADDR_LEN'(cols[i]));
        exp_q.push_back(col_word(1'b1, cols[i]));
      end
    end
    return cols.size() - 3;
  endfunction

  // ---------------- monitor ----------------
  int     img_idx = 0;
  longint last_img = 0;
  bit     res_exp = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      res_exp = 1'b0;
      img_idx = 0;
    end else begin
      if (bus.res_valid || res_exp) check("res_valid", bus.res_valid, res_exp);
      if (bus.res_valid) res_cnt++;
      res_exp = 1'b0;
      if (bus.rd_en) begin
        check("rd_en_with_valid", bus.valid, 0);
        if (addr_q.size() == 0) check("rd_unexpected", bus.rd_en, 0);
        else check("rd_addr", bus.addr, addr_q.pop_front());
      end
      if (bus.valid) begin
        if (exp_q.size() == 0) check("strobe_unexpected", bus.valid, 0);
        else check("strobe", {bus.selecK_I, bus.dato0, bus.dato1, bus.dato2}, exp_q.pop_front());
        if (bus.selecK_I) begin
          if (img_idx > 0) check("strobe_gap", cyc - last_img, GAP);
          last_img = cyc;
          res_exp = (img_idx >= 3);
          img_idx++;
        end
      end
      if (o_done) done_cnt++;
      if (!o_busy && !bus.valid) img_idx = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input int width, input int kbase, input int ibase);
    @(negedge clk);
    i_width = ADDR_LEN'(width);
    i_kbase = ADDR_LEN'(kbase);
    i_ibase = ADDR_LEN'(ibase);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic run_job(input int width, input int kbase, input int ibase);
    int exp_res, r0, d0, busy_cyc, budget;
    bit deg;
    deg = width < ((TB_PAD != 0) ? 1 : 3);
    exp_res = model_job(width, kbase, ibase);
    r0 = res_cnt;
    d0 = done_cnt;
    pulse_start(width, kbase, ibase);
    busy_cyc = o_busy ? 1 : 0;
    budget = 200 + (width + 4) * GAP * 2;
    while (!o_done && budget > 0) begin
      @(negedge clk);
      if (o_busy) busy_cyc++;
      budget--;
    end
    check("done_seen", o_done, 1);
    check("busy_low_at_done", o_busy, 0);
    if (deg) check("deg_busy_cycles", busy_cyc, 1);
    @(negedge clk);
    check("done_one_cycle", o_done, 0);
    check("done_count", done_cnt - d0, 1);
    check("res_count", res_cnt - r0, exp_res);
    check("strobes_left", exp_q.size(), 0);
    check("reads_left", addr_q.size(), 0);
    exp_q.delete();
    addr_q.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_addr"}, bus.addr, 0);
    check({tag, "_rd_en"}, bus.rd_en, 0);
    check({tag, "_dato"}, {bus.dato0, bus.dato1, bus.dato2}, 0);
    check({tag, "_selecK_I"}, bus.selecK_I, 0);
    check({tag, "_valid"}, bus.valid, 0);
    check({tag, "_res_valid"}, bus.res_valid, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_state"}, int'(dbg_state), int'(ST_IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d0, dummy;
    rst_n = 1'b0;
    i_start = 1'b0;
    i_width = '0;
    i_kbase = '0;
    i_ibase = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_job(5, 0, 16);
    run_job((TB_PAD != 0) ? 0 : 2, 7, 40);
    run_job(2, 100, 200);
    run_job(4, 3, 1022);
    run_job(4, 1023, 500);
    for (int i = 0; i < 6; i++)
      run_job($urandom_range(3, 12), $urandom_range(0, AMOD - 1), $urandom_range(0, AMOD - 1));

    // Restart attempt mid-image-phase, then abort with reset.
    dummy = model_job(20, 10, 300);
    pulse_start(20, 10, 300);
    repeat (30) @(negedge clk);
    i_width = ADDR_LEN'(3);
    i_kbase = ADDR_LEN'(900);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (21) @(negedge clk);
    check("abort_still_busy", o_busy, 1);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("abort");
    exp_q.delete();
    addr_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("no_done_after_abort", done_cnt - d0, 0);
    check("idle_after_abort", int'(dbg_state), int'(ST_IDLE));
    run_job(6, 20, 60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
